// File: rtl/sprite_mem_arbiter.sv
// sprite_mem_arbiter
// Round-robin sharing of one synchronous-read sprite SRAM between the P1
// sprite, P2 sprite and ball fetchers. A grant in cycle T produces a one-hot
// response strobe in cycle T+3, tagged with the originating requester.
module sprite_mem_arbiter #(
  parameter int                    ADDR_WIDTH  = 17,
  parameter int                    DATA_WIDTH  = 12,
  parameter logic [DATA_WIDTH-1:0] TRANS_COLOR = 12'h0F0,
  parameter int                    P2_BASE     = 4096,
  parameter int                    BALL_BASE   = 8192
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [2:0]              req,
  input  logic [3*ADDR_WIDTH-1:0] req_addr,
  output logic [2:0]              gnt,
  output logic                    sram_en,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  input  logic [DATA_WIDTH-1:0]   sram_data,
  output logic [2:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    rsp_opaque,
  output logic [7:0]              busy_cnt
);

  // Round-robin pointer: the requester scanned first this cycle.
  typedef enum logic [1:0] {
    PTR_P1   = 2'd0,
    PTR_P2   = 2'd1,
    PTR_BALL = 2'd2
  } ptr_e;

  // Successor in the fixed P1 -> P2 -> ball -> P1 ring.
  function automatic ptr_e next_ptr(input ptr_e p);
    case (p)
      PTR_P1:   next_ptr = PTR_P2;
      PTR_P2:   next_ptr = PTR_BALL;
      PTR_BALL: next_ptr = PTR_P1;
      default:  next_ptr = PTR_P1;
    endcase
  endfunction

  // Requester id to one-hot strobe; the unused code maps to no strobe.
  function automatic logic [2:0] id_onehot(input logic [1:0] id);
    case (id)
      2'd0:    id_onehot = 3'b001;
      2'd1:    id_onehot = 3'b010;
      2'd2:    id_onehot = 3'b100;
      default: id_onehot = 3'b000;
    endcase
  endfunction

  // Word offset of each requester's image inside the shared SRAM.
  function automatic logic [ADDR_WIDTH-1:0] base_of(input logic [1:0] id);
    case (id)
      2'd0:    base_of = {ADDR_WIDTH{1'b0}};
      2'd1:    base_of = ADDR_WIDTH'(P2_BASE);
      2'd2:    base_of = ADDR_WIDTH'(BALL_BASE);
      default: base_of = {ADDR_WIDTH{1'b0}};
    endcase
  endfunction

  ptr_e                  ptr_r;
  ptr_e                  ptr_nxt_s;
  ptr_e                  cand0_s;
  ptr_e                  cand1_s;
  ptr_e                  cand2_s;
  ptr_e                  win_id_s;
  logic                  win_s;
  logic [3:0]            req_ext_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [ADDR_WIDTH-1:0] phys_addr_s;
  logic                  tag0_valid_r;
  logic [1:0]            tag0_id_r;
  logic                  tag1_valid_r;
  logic [1:0]            tag1_id_r;

  // Arbitration: first requesting bit in ring order from the pointer wins;
  // reset and flush block any acceptance so a pending req stays pending.
  always_comb begin
    req_ext_s = {1'b0, req};
    cand0_s   = ptr_r;
    cand1_s   = next_ptr(ptr_r);
    cand2_s   = next_ptr(cand1_s);
    win_s     = 1'b0;
    win_id_s  = PTR_P1;
    if (reset || flush) begin
      win_s = 1'b0;
    end else if (req_ext_s[cand0_s]) begin
      win_s    = 1'b1;
      win_id_s = cand0_s;
    end else if (req_ext_s[cand1_s]) begin
      win_s    = 1'b1;
      win_id_s = cand1_s;
    end else if (req_ext_s[cand2_s]) begin
      win_s    = 1'b1;
      win_id_s = cand2_s;
    end else begin
      win_s = 1'b0;
    end
  end

  assign gnt = win_s ? id_onehot(win_id_s) : 3'b000;

  // Pointer next state: restart at P1 on flush, else step past the winner.
  always_comb begin
    ptr_nxt_s = ptr_r;
    if (flush) begin
      ptr_nxt_s = PTR_P1;
    end else if (win_s) begin
      ptr_nxt_s = next_ptr(win_id_s);
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Winner's local address plus its image base, truncated to the SRAM width.
  always_comb begin
    sel_addr_s = req_addr[0 +: ADDR_WIDTH];
    case (win_id_s)
      PTR_P1:   sel_addr_s = req_addr[0 +: ADDR_WIDTH];
      PTR_P2:   sel_addr_s = req_addr[ADDR_WIDTH +: ADDR_WIDTH];
      PTR_BALL: sel_addr_s = req_addr[2*ADDR_WIDTH +: ADDR_WIDTH];
      default:  sel_addr_s = req_addr[0 +: ADDR_WIDTH];
    endcase
    phys_addr_s = sel_addr_s + base_of(win_id_s);
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= PTR_P1;
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

  // Stage 0: launch the SRAM read and remember who asked for it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sram_en      <= 1'b0;
      sram_addr    <= {ADDR_WIDTH{1'b0}};
      tag0_valid_r <= 1'b0;
      tag0_id_r    <= 2'd0;
    end else if (flush) begin
      sram_en      <= 1'b0;
      tag0_valid_r <= 1'b0;
    end else begin
      sram_en      <= win_s;
      tag0_valid_r <= win_s;
      tag0_id_r    <= win_id_s;
      if (win_s) begin
        sram_addr <= phys_addr_s;
      end
    end
  end

  // Stage 1: tag follows the read while the SRAM registers its data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag1_valid_r <= 1'b0;
      tag1_id_r    <= 2'd0;
    end else if (flush) begin
      tag1_valid_r <= 1'b0;
    end else begin
      tag1_valid_r <= tag0_valid_r;
      tag1_id_r    <= tag0_id_r;
    end
  end

  // Stage 2: return the pixel to its requester; data holds between responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid  <= 3'b000;
      rsp_data   <= {DATA_WIDTH{1'b0}};
      rsp_opaque <= 1'b0;
    end else if (flush) begin
      rsp_valid <= 3'b000;
    end else if (tag1_valid_r) begin
      rsp_valid  <= id_onehot(tag1_id_r);
      rsp_data   <= sram_data;
      rsp_opaque <= (sram_data != TRANS_COLOR);
    end else begin
      rsp_valid <= 3'b000;
    end
  end

  // Grants since the last flush, saturating at the counter maximum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_cnt <= 8'd0;
    end else if (flush) begin
      busy_cnt <= 8'd0;
    end else if (win_s && (busy_cnt != 8'd255)) begin
      busy_cnt <= busy_cnt + 8'd1;
    end
  end

endmodule

// File: doc/sprite_mem_arbiter.md
Name: sprite_mem_arbiter

Overview:
- Shares one synchronous-read sprite SRAM port between three pixel fetchers: P1 sprite, P2 sprite and ball.
- The renderer drops from one SRAM instance per object to one shared instance. The pixel clock runs at clk/4, so three fetches fit in each pixel period.
- Arbitration is round-robin. Each granted read returns its data to the originating requester with a fixed latency, plus a transparency flag.

Parameters:
- ADDR_WIDTH, 17, SRAM address width.
- DATA_WIDTH, 12, pixel width (RGB444).
- TRANS_COLOR, 12'h0F0, colour treated as transparent.
- P2_BASE, 4096, word offset added to P2 addresses (second sprite image).
- BALL_BASE, 8192, word offset added to ball addresses.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous one-cycle pulse, driven at frame start
- req  in  3  read request; bit0=P1, bit1=P2, bit2=ball
- req_addr  in  3*ADDR_WIDTH  per-requester local address; bit slice k belongs to requester k
- gnt  out  3  one-hot grant, combinational, same cycle as the accepted req
- sram_en  out  1  SRAM read enable, registered
- sram_addr  out  ADDR_WIDTH  SRAM address, registered, includes base offset
- sram_data  in  DATA_WIDTH  SRAM read data, valid one cycle after sram_en/sram_addr
- rsp_valid  out  3  one-hot response strobe, registered
- rsp_data  out  DATA_WIDTH  returned pixel, registered
- rsp_opaque  out  1  1 when rsp_data != TRANS_COLOR; meaningful only with rsp_valid
- busy_cnt  out  8  number of requests granted since the last flush, saturating

Behaviour:
- Reset (async, active-high) clears:
  - sram_en, sram_addr, rsp_valid, rsp_data, rsp_opaque, busy_cnt all go to 0.
  - The round-robin pointer goes to 0 (P1 highest priority).
  - Both pipeline tag stages become invalid.
- Arbitration, each cycle:
  - Scan req starting at the pointer, in order ptr, ptr+1, ptr+2 mod 3.
  - The first set bit wins, and gnt goes one-hot on it.
  - If req==0, gnt=0 and the pointer is held.
  - At most one grant per cycle.
- Pointer update: after a grant to k, the pointer becomes (k+1) mod 3. Any requester holding req is therefore granted within 3 cycles.
- Requester contract:
  - Hold req and req_addr stable until gnt is seen.
  - gnt acts as the acknowledge. A new address may be presented the next cycle.
- Stage 0 (edge ending the grant cycle T):
  - sram_en <= |gnt.
  - sram_addr <= req_addr[k] + base(k). Base is 0 for P1, P2_BASE for P2, BALL_BASE for ball.
  - The addition truncates to ADDR_WIDTH.
  - tag0 <= {valid=|gnt, id=k}.
- Stage 1 (edge ending T+1): tag1 <= tag0, and the SRAM registers its data.
- Stage 2 (edge ending T+2):
  - rsp_valid <= onehot(tag1.id) if tag1.valid, else 0.
  - rsp_data <= sram_data.
  - rsp_opaque <= (sram_data != TRANS_COLOR).
- Latency: rsp_valid is high in cycle T+3 for the request granted in cycle T.
- Throughput: one request per cycle. Responses come back in grant order.
- rsp_data and rsp_opaque are held when no response is issued. rsp_valid is a single-cycle pulse.
- busy_cnt: increments on each grant and saturates at 255.
- flush (synchronous):
  - Invalidates tag0 and tag1, so in-flight reads produce no rsp_valid.
  - Sets the pointer to 0, clears busy_cnt to 0 and forces sram_en to 0.
  - gnt is forced to 0 during the flush cycle, so requests are not accepted that cycle.
- flush together with a grant-eligible req: flush wins, and the request stays pending to the next cycle.
- Reset asserted mid-operation: every in-flight response is lost. Requesters re-issue after reset.
- The SRAM is strictly read-only through this block. No write path exists.

Test Plan:
- Reset, then req=001 with addr0=5 → gnt=001 the same cycle; sram_addr=5 and sram_en=1 next cycle. With sram_data=12'hABC, rsp_valid=001, rsp_data=ABC and rsp_opaque=1 in cycle T+3.
- req=111 held continuously, with each requester presenting a new address after its gnt → grants rotate 001,010,100,001… Each requester gets one grant per 3 cycles, and busy_cnt reaches 6 after 6 cycles.
- req=010 with addr1=10 → sram_addr=4106 (10+4096). req=100 with addr2=3 → sram_addr=8195.
- SRAM returns 12'h0F0 → rsp_opaque=0, rsp_data=0F0.
- flush two cycles after a grant → no rsp_valid for that read. The pointer returns to P1, busy_cnt=0, and a req presented during the flush cycle is granted the following cycle.
- busy_cnt driven through 300 grants → holds at 255. Asserting reset asynchronously mid-stream clears all outputs immediately, without waiting for a clock edge.
